multdiv_unit: RTL and testbench

Parametrised iterative signed multiply/divide unit; the multi-cycle companion to the single-cycle ALU in the execute stage.
- Accepts one-cycle start pulses (ctrl_MULT / ctrl_DIV).
- Runs a WIDTH-iteration shift-add (mult) or non-restoring (div) datapath.
- Returns a registered result with a one-cycle ready pulse and an exception flag.
- The processor stalls on busy and releases on data_resultRDY.

---
 rtl/multdiv_unit_pkg.sv | 23 ++
 rtl/multdiv_unit_nbit_addsub.sv | 20 ++
 rtl/multdiv_unit.sv | 173 +++++++++++++++++
 tb/tb_multdiv_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package multdiv_unit_pkg;

  // Controller states; the encoding is visible to debug tooling.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Booth pair {q0, q-1}: 00/11 leave the accumulator unchanged.
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  localparam int unsigned MAX_WIDTH = 64;

  // Most negative two's-complement value of a given width, zero-extended.
  function automatic logic [MAX_WIDTH-1:0] min_int(input int unsigned width);
    return MAX_WIDTH'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/multdiv_unit_nbit_addsub.sv
// Adder-subtractor shared by the Booth and non-restoring datapaths.
module nbit_addsub #(
  parameter int unsigned WIDTH = 33
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  logic [WIDTH-1:0] w_b;

  // Subtract as a + ~b + 1.
  assign w_b             = i_b ^ {WIDTH{i_sub}};
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, w_b} + (WIDTH+1)'(i_sub);
  assign o_ovf           = (i_a[WIDTH-1] == w_b[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (non-restoring) unit.
module multdiv_unit
  import multdiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned AW    = WIDTH + 1;
  localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(min_int(WIDTH));

  state_e           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [AW-1:0]    r_hi;      // Booth upper accumulator / partial remainder
  logic [WIDTH-1:0] r_lo;      // Booth multiplier+product low / dividend->quotient
  logic             r_qm1;     // Booth q(-1)
  logic [WIDTH-1:0] r_m;       // multiplicand / divisor magnitude
  logic             r_neg;     // quotient must be negated
  logic             r_div_ovf; // MIN / -1

  logic             w_start_mul, w_start_div, w_start_err, w_last_iter;
  logic [AW-1:0]    w_add_a, w_add_b, w_sum;
  logic             w_add_sub, w_unused_cout, w_unused_ovf;
  logic [AW-1:0]    w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo, w_div_q, w_div_res, w_abs_a, w_abs_b;
  logic             w_mul_ovf;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state decode and start strobes.
  always_comb begin
    w_state_next = r_state;
    w_start_mul  = 1'b0;
    w_start_div  = 1'b0;
    w_start_err  = 1'b0;
    w_last_iter  = (r_cnt == CNT_W'(WIDTH - 1));
    case (r_state)
      ST_IDLE: begin
        if (ctrl_MULT && ctrl_DIV) begin
          w_state_next = ST_DONE;
          w_start_err  = 1'b1;
        end else if (ctrl_MULT) begin
          w_state_next = ST_MUL;
          w_start_mul  = 1'b1;
        end else if (ctrl_DIV) begin
          if (data_operandB == '0) begin
            w_state_next = ST_DONE;
            w_start_err  = 1'b1;
          end else begin
            w_state_next = ST_DIV;
            w_start_div  = 1'b1;
          end
        end
      end
      ST_MUL, ST_DIV: if (w_last_iter) w_state_next = ST_DONE;
      ST_DONE:        w_state_next = ST_IDLE;
      default:        w_state_next = ST_IDLE;
    endcase
  end

  // Adder operand steering: Booth add/sub in MUL, shift-then-add/sub in DIV.
  always_comb begin
    w_add_a   = r_hi;
    w_add_b   = '0;
    w_add_sub = 1'b0;
    if (r_state == ST_DIV) begin
      w_add_a   = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
      w_add_b   = {1'b0, r_m};
      w_add_sub = ~r_hi[WIDTH];
    end else begin
      case ({r_lo[0], r_qm1})
        BOOTH_ADD: w_add_b = {r_m[WIDTH-1], r_m};
        BOOTH_SUB: begin
          w_add_b   = {r_m[WIDTH-1], r_m};
          w_add_sub = 1'b1;
        end
        default: ;
      endcase
    end
  end

  nbit_addsub #(.WIDTH(AW)) u_addsub (
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .i_sub  (w_add_sub),
    .o_sum  (w_sum),
    .o_cout (w_unused_cout),
    .o_ovf  (w_unused_ovf)
  );

  // Iteration results; the remainder is never exposed, so it is left uncorrected.
  assign w_mul_hi  = {w_sum[WIDTH], w_sum[WIDTH:1]};
  assign w_mul_lo  = {w_sum[0], r_lo[WIDTH-1:1]};
  assign w_mul_ovf = ~((&{w_mul_hi, w_mul_lo[WIDTH-1]}) | ~(|{w_mul_hi, w_mul_lo[WIDTH-1]}));
  assign w_div_q   = {r_lo[WIDTH-2:0], ~w_sum[WIDTH]};
  assign w_div_res = r_neg ? -w_div_q : w_div_q;
  assign w_abs_a   = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign w_abs_b   = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  // Datapath, counter and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cnt          <= '0;
      r_hi           <= '0;
      r_lo           <= '0;
      r_qm1          <= 1'b0;
      r_m            <= '0;
      r_neg          <= 1'b0;
      r_div_ovf      <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= (w_state_next == ST_DONE);
      busy           <= (w_state_next != ST_IDLE);
      if (w_start_mul) begin
        r_cnt <= '0;
        r_hi  <= '0;
        r_lo  <= data_operandB;
        r_qm1 <= 1'b0;
        r_m   <= data_operandA;
      end
      if (w_start_div) begin
        r_cnt     <= '0;
        r_hi      <= '0;
        r_lo      <= w_abs_a;
        r_m       <= w_abs_b;
        r_neg     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        r_div_ovf <= (data_operandA == MIN_VAL) && (&data_operandB);
      end
      if (w_start_err) begin
        data_result    <= '0;
        data_exception <= 1'b1;
      end
      if (r_state == ST_MUL) begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_hi  <= w_mul_hi;
        r_lo  <= w_mul_lo;
        r_qm1 <= r_lo[0];
        if (w_last_iter) begin
          data_result    <= w_mul_lo;
          data_exception <= w_mul_ovf;
        end
      end
      if (r_state == ST_DIV) begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_hi  <= w_sum;
        r_lo  <= w_div_q;
        if (w_last_iter) begin
          data_result    <= w_div_res;
          data_exception <= r_div_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed and model-based bench for multdiv_unit at WIDTH 32, 16 and 8.
module tb_multdiv_unit;

  typedef struct packed {
    logic        mul;
    logic        div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
    int          lat;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] a32, b32, res32;
  logic [15:0] a16, b16, res16;
  logic [7:0]  a8, b8, res8;
  logic        m32, d32, exc32, rdy32, busy32;
  logic        m16, d16, exc16, rdy16, busy16;
  logic        m8, d8, exc8, rdy8, busy8;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  multdiv_unit #(.WIDTH(32)) u_dut32 (
    .clock(clock), .reset_n(reset_n), .data_operandA(a32), .data_operandB(b32),
    .ctrl_MULT(m32), .ctrl_DIV(d32), .data_result(res32), .data_exception(exc32),
    .data_resultRDY(rdy32), .busy(busy32));

  multdiv_unit #(.WIDTH(16)) u_dut16 (
    .clock(clock), .reset_n(reset_n), .data_operandA(a16), .data_operandB(b16),
    .ctrl_MULT(m16), .ctrl_DIV(d16), .data_result(res16), .data_exception(exc16),
    .data_resultRDY(rdy16), .busy(busy16));

  multdiv_unit #(.WIDTH(8)) u_dut8 (
    .clock(clock), .reset_n(reset_n), .data_operandA(a8), .data_operandB(b8),
    .ctrl_MULT(m8), .ctrl_DIV(d8), .data_result(res8), .data_exception(exc8),
    .data_resultRDY(rdy8), .busy(busy8));

  function automatic logic [31:0] get_res(input int w);
    case (w)
      8:       return {24'd0, res8};
      16:      return {16'd0, res16};
      default: return res32;
    endcase
  endfunction

  function automatic logic get_exc(input int w);
    case (w)
      8:       return exc8;
      16:      return exc16;
      default: return exc32;
    endcase
  endfunction

  function automatic logic get_rdy(input int w);
    case (w)
      8:       return rdy8;
      16:      return rdy16;
      default: return rdy32;
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      8:       return busy8;
      16:      return busy16;
      default: return busy32;
    endcase
  endfunction

  task automatic drive(input int w, input logic mul, input logic div,
                       input logic [31:0] a, input logic [31:0] b);
    case (w)
      8:       begin a8 = a[7:0];   b8 = b[7:0];   m8 = mul;  d8 = div;  end
      16:      begin a16 = a[15:0]; b16 = b[15:0]; m16 = mul; d16 = div; end
      default: begin a32 = a;       b32 = b;       m32 = mul; d32 = div; end
    endcase
  endtask

  // Called at a negedge: one-cycle start pulse, then wait for RDY and look one cycle past it.
  task automatic run_op(input int w, input logic mul, input logic div,
                        input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic exc, output int lat,
                        output int bcnt, output logic post_rdy, output logic post_busy);
    drive(w, mul, div, a, b);
    @(negedge clock);
    drive(w, 1'b0, 1'b0, a, b);
    lat  = 0;
    bcnt = 0;
    while (!get_rdy(w) && lat < 200) begin
      if (get_busy(w)) bcnt++;
      lat++;
      @(negedge clock);
    end
    if (!get_rdy(w)) begin
      checks++; failures++;
      $display("FAIL rdy_timeout w=%0d got=no_rdy exp=rdy", w);
    end
    res = get_res(w);
    exc = get_exc(w);
    @(negedge clock);
    post_rdy  = get_rdy(w);
    post_busy = get_busy(w);
  endtask

  // Sign-extend the low w bits of v.
  function automatic longint sx(input longint v, input int w);
    longint t;
    t = v << (64 - w);
    return t >>> (64 - w);
  endfunction

  // Reference: full-precision signed arithmetic, then wrap and flag anything that does not fit.
  function automatic void model(input int w, input logic mul, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] res, output logic exc);
    longint sa, sb, r, mask;
    mask = (longint'(1) << w) - 1;
    sa   = sx(longint'(a), w);
    sb   = sx(longint'(b), w);
    if (!mul && sb == 0) begin
      res = '0;
      exc = 1'b1;
      return;
    end
    r   = mul ? sa * sb : sa / sb;
    res = 32'(r & mask);
    exc = (sx(r & mask, w) != r);
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    drive(32, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(16, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(8,  1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(negedge clock);
    checks++; if (res32 !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", res32); end
    checks++; if (exc32 !== 1'b0) begin failures++; $display("FAIL reset_exception got=%b exp=0", exc32); end
    checks++; if (rdy32 !== 1'b0) begin failures++; $display("FAIL reset_rdy got=%b exp=0", rdy32); end
    checks++; if (busy32 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy32); end
    checks++; if ({res8, res16, busy8, busy16} !== 26'd0) begin
      failures++; $display("FAIL reset_narrow got=%h exp=0", {res8, res16, busy8, busy16});
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_mult();
    vec_t tv [4];
    logic [31:0] res; logic exc, prdy, pbusy; int lat, bcnt;
    tv = '{'{1'b1, 1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 32},
           '{1'b1, 1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 32},
           '{1'b1, 1'b0, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 1'b1, 32},
           '{1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32}};
    for (int i = 0; i < 4; i++) begin
      run_op(32, tv[i].mul, tv[i].div, tv[i].a, tv[i].b, res, exc, lat, bcnt, prdy, pbusy);
      checks++; if (res !== tv[i].res) begin failures++; $display("FAIL mult%0d_result got=%h exp=%h", i, res, tv[i].res); end
      checks++; if (exc !== tv[i].exc) begin failures++; $display("FAIL mult%0d_exception got=%b exp=%b", i, exc, tv[i].exc); end
      checks++; if (lat != tv[i].lat) begin failures++; $display("FAIL mult%0d_latency got=%0d exp=%0d", i, lat, tv[i].lat); end
      checks++; if (bcnt != tv[i].lat) begin failures++; $display("FAIL mult%0d_busy_cycles got=%0d exp=%0d", i, bcnt, tv[i].lat); end
      checks++; if ({prdy, pbusy} !== 2'b00) begin failures++; $display("FAIL mult%0d_after_rdy got=%b exp=00", i, {prdy, pbusy}); end
    end
  endtask

  task automatic test_div();
    vec_t tv [5];
    logic [31:0] res; logic exc, prdy, pbusy; int lat, bcnt;
    tv = '{'{1'b0, 1'b1, 32'hFFFFFFEF, 32'd5,        32'hFFFFFFFD, 1'b0, 32},
           '{1'b0, 1'b1, 32'd100,      32'd0,        32'h00000000, 1'b1, 0},
           '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 32},
           '{1'b0, 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003, 1'b0, 32},
           '{1'b0, 1'b1, 32'd3,        32'd7,        32'h00000000, 1'b0, 32}};
    for (int i = 0; i < 5; i++) begin
      run_op(32, tv[i].mul, tv[i].div, tv[i].a, tv[i].b, res, exc, lat, bcnt, prdy, pbusy);
      checks++; if (res !== tv[i].res) begin failures++; $display("FAIL div%0d_result got=%h exp=%h", i, res, tv[i].res); end
      checks++; if (exc !== tv[i].exc) begin failures++; $display("FAIL div%0d_exception got=%b exp=%b", i, exc, tv[i].exc); end
      checks++; if (lat != tv[i].lat) begin failures++; $display("FAIL div%0d_latency got=%0d exp=%0d", i, lat, tv[i].lat); end
      checks++; if ({prdy, pbusy} !== 2'b00) begin failures++; $display("FAIL div%0d_after_rdy got=%b exp=00", i, {prdy, pbusy}); end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] res; logic exc, prdy, pbusy; int lat, bcnt;
    run_op(32, 1'b1, 1'b1, 32'd9, 32'd4, res, exc, lat, bcnt, prdy, pbusy);
    checks++; if (res !== 32'd0) begin failures++; $display("FAIL illegal_result got=%h exp=0", res); end
    checks++; if (exc !== 1'b1) begin failures++; $display("FAIL illegal_exception got=%b exp=1", exc); end
    checks++; if (lat != 0) begin failures++; $display("FAIL illegal_latency got=%0d exp=0", lat); end
  endtask

  task automatic test_ignored_starts();
    int pulses = 0;
    logic [31:0] first = '0;
    drive(32, 1'b1, 1'b0, 32'd7, 32'hFFFFFFFD);
    @(negedge clock);
    drive(32, 1'b0, 1'b0, 32'd100, 32'd5);
    for (int cyc = 0; cyc < 45; cyc++) begin
      d32 = (cyc == 5);
      if (rdy32) begin
        pulses++;
        if (pulses == 1) first = res32;
        m32 = 1'b1; a32 = 32'd3; b32 = 32'd3;
      end else begin
        m32 = 1'b0;
      end
      @(negedge clock);
    end
    m32 = 1'b0; d32 = 1'b0;
    checks++; if (pulses != 1) begin failures++; $display("FAIL ignore_rdy_pulses got=%0d exp=1", pulses); end
    checks++; if (first !== 32'hFFFFFFEB) begin failures++; $display("FAIL ignore_first_result got=%h exp=ffffffeb", first); end
    checks++; if (res32 !== 32'hFFFFFFEB) begin failures++; $display("FAIL ignore_result_held got=%h exp=ffffffeb", res32); end
    checks++; if (busy32 !== 1'b0) begin failures++; $display("FAIL ignore_busy_idle got=%b exp=0", busy32); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res; logic exc, prdy, pbusy; int lat, bcnt;
    run_op(32, 1'b1, 1'b0, 32'hFFFFFFFB, 32'd6, res, exc, lat, bcnt, prdy, pbusy);
    checks++; if (res !== 32'hFFFFFFE2) begin failures++; $display("FAIL b2b_first_result got=%h exp=ffffffe2", res); end
    run_op(32, 1'b0, 1'b1, 32'hFFFFFFEF, 32'd5, res, exc, lat, bcnt, prdy, pbusy);
    checks++; if (res !== 32'hFFFFFFFD) begin failures++; $display("FAIL b2b_second_result got=%h exp=fffffffd", res); end
    checks++; if (lat != 32) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=32", lat); end
  endtask

  task automatic test_reset_mid_op();
    int pulses = 0;
    drive(32, 1'b1, 1'b0, 32'd7, 32'd9);
    @(negedge clock);
    drive(32, 1'b0, 1'b0, 32'd7, 32'd9);
    repeat (9) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    checks++; if ({res32, exc32, rdy32, busy32} !== 35'd0) begin
      failures++; $display("FAIL midreset_outputs got=%h exp=0", {res32, exc32, rdy32, busy32});
    end
    reset_n = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (rdy32) pulses++;
      @(negedge clock);
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL midreset_no_rdy got=%0d exp=0", pulses); end
    checks++; if (busy32 !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy32); end
  endtask

  task automatic test_sweep(input int w);
    logic [31:0] mask, a, b, res, eres; logic mul, exc, eexc, prdy, pbusy; int lat, bcnt, elat;
    mask = 32'hFFFFFFFF >> (32 - w);
    for (int i = 0; i < 24; i++) begin
      a   = $urandom & mask;
      b   = $urandom & mask;
      mul = (i % 2 == 0);
      if (i % 5 == 3) b = '0;
      if (i == 6 || i == 7) begin a = 32'd1 << (w - 1); b = mask; end
      model(w, mul, a, b, eres, eexc);
      elat = (!mul && b == '0) ? 0 : w;
      run_op(w, mul, !mul, a, b, res, exc, lat, bcnt, prdy, pbusy);
      checks++; if (res !== eres || exc !== eexc) begin
        failures++;
        $display("FAIL sweep%0d_%0d mul=%b a=%h b=%h got=%h/%b exp=%h/%b", w, i, mul, a, b, res, exc, eres, eexc);
      end
      checks++; if (lat != elat) begin failures++; $display("FAIL sweep%0d_%0d_latency got=%0d exp=%0d", w, i, lat, elat); end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_illegal();
    test_ignored_starts();
    test_back_to_back();
    test_reset_mid_op();
    test_sweep(8);
    test_sweep(16);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
